// File: rtl/ahb_rr_master_arbiter_pkg.sv
// Shared types for the round-robin AHB-lite master arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } arb_state_t;

endpackage

// File: rtl/ahb_rr_master_arbiter_if.sv
// Requester-side handshake plus AHB-lite master signals for the arbiter.
interface ahb_rr_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [1:0]                Htrans;
  logic [ADDR_W-1:0]         Haddr;
  logic                      Hwrite;
  logic [DATA_W-1:0]         Hwdata;
  logic                      Hreadyin;
  logic                      Hreadyout;
  logic [1:0]                Hresp;
  logic [DATA_W-1:0]         Hrdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Hreadyout, Hresp, Hrdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           Htrans, Haddr, Hwrite, Hwdata, Hreadyin
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Hreadyout, Hresp, Hrdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           Htrans, Haddr, Hwrite, Hwdata, Hreadyin
  );

endinterface

// File: rtl/ahb_rr_master_arbiter_rr_arbiter.sv
// Round-robin grant selection; the pointer holds the last granted index.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 grant_en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int W = $clog2(N);

  logic [W-1:0] ptr;
  logic         found;

  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = W'(idx);
      end
    end
    if (grant_en && found) grant[grant_idx] = 1'b1;
  end

  // Reset to N-1 so that requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= W'(N - 1);
    else if (grant_en && found) ptr <= grant_idx;
  end

endmodule

// File: rtl/ahb_rr_master_arbiter.sv
// Shares one AHB-lite port among NUM_REQ requesters, single-beat NONSEQ, one outstanding.
// state  | meaning
// S_IDLE | no transfer; grant on any req_valid
// S_ADDR | NONSEQ address phase, wait for Hreadyout
// S_DATA | data phase; complete, respond and re-arbitrate on Hreadyout
module ahb_rr_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  ahb_rr_master_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t         state, state_nxt;
  logic               hready_q;
  logic               grant_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ID_W-1:0]    id_q;
  logic               err_q;
  logic               hresp_err;
  logic               done;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;

  assign hresp_err = (bus.Hresp == HRESP_ERROR);
  assign done      = (state == S_DATA) && bus.Hreadyout;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (Hclk),
    .rst_n     (Hresetn),
    .req       (bus.req_valid),
    .grant_en  (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants in S_IDLE wait for hready_q so nothing is accepted while in reset.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      S_IDLE: begin
        grant_en = hready_q;
        if (hready_q && |bus.req_valid) state_nxt = S_ADDR;
      end
      S_ADDR: if (bus.Hreadyout) state_nxt = S_DATA;
      S_DATA: if (bus.Hreadyout) begin
        grant_en  = 1'b1;
        state_nxt = (|bus.req_valid) ? S_ADDR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= S_IDLE;
      hready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      hready_q <= 1'b1;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else if (|grant) begin
      addr_q  <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      write_q <= bus.req_write[grant_idx];
      wdata_q <= bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
      id_q    <= grant_idx;
      err_q   <= 1'b0;
    end else if (state == S_DATA && hresp_err) begin
      err_q   <= 1'b1;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= done;
      if (done) begin
        rsp_id_q    <= id_q;
        rsp_rdata_q <= write_q ? '0 : bus.Hrdata;
        rsp_err_q   <= err_q | hresp_err;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.Htrans    = (state == S_ADDR) ? NONSEQ : IDLE;
  assign bus.Haddr     = addr_q;
  assign bus.Hwrite    = write_q;
  assign bus.Hwdata    = (state == S_DATA && write_q) ? wdata_q : '0;
  assign bus.Hreadyin  = hready_q;

endmodule

// File: tb/tb_ahb_rr_master_arbiter.sv
// Directed bench for ahb_rr_master_arbiter with two requesters.
module tb_ahb_rr_master_arbiter;
  logic Hclk;
  logic Hresetn;
  int   vectors;
  int   miscompares;

  ahb_rr_master_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb_rr_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Hclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_write[i]          = w;
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    Hresetn       = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = '0;

    // reset state, with a request pending that must not be accepted
    set_req(0, 1'b1, 32'h0000_0010, 32'h0);
    tick(); #1;
    chk("rst_htrans", bus.Htrans, 2'b00);
    chk("rst_hreadyin", bus.Hreadyin, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_haddr", bus.Haddr, 32'h0);
    Hresetn = 1'b1;
    bus.req_valid = '0;
    tick(); #1;
    chk("hreadyin_after_release", bus.Hreadyin, 1'b1);

    // 1: single write from requester 0
    set_req(0, 1'b1, 32'h8000_0011, 32'h8000_0011);
    #1 chk("t1_req_ready", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0; #1;
    chk("t1_nonseq", bus.Htrans, 2'b10);
    chk("t1_haddr", bus.Haddr, 32'h8000_0011);
    chk("t1_hwrite", bus.Hwrite, 1'b1);
    tick(); #1;
    chk("t1_dphase_idle", bus.Htrans, 2'b00);
    chk("t1_hwdata", bus.Hwdata, 32'h8000_0011);
    chk("t1_no_rsp_yet", bus.rsp_valid, 1'b0);
    tick(); #1;
    chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp_id", bus.rsp_id, 1'b0);
    chk("t1_rsp_err", bus.rsp_err, 1'b0);
    chk("t1_rsp_rdata", bus.rsp_rdata, 32'h0);
    tick(); #1;
    chk("t1_rsp_pulse", bus.rsp_valid, 1'b0);

    // fresh reset so the pointer starts at requester 0 again
    Hresetn = 1'b0;
    tick();
    Hresetn = 1'b1;
    tick();

    // 2: both requesters valid, 4 writes each, strict alternation
    set_req(0, 1'b1, 32'h0000_0100, 32'h0000_1000);
    set_req(1, 1'b1, 32'h0000_0200, 32'h0000_2000);
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_req_ready", bus.req_ready, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) chk("t2_dphase_idle", bus.Htrans, 2'b00);
      tick(); #1;
      chk("t2_nonseq", bus.Htrans, 2'b10);
      chk("t2_haddr", bus.Haddr, (k % 2 == 0) ? 64'h100 : 64'h200);
      if (k > 0) begin
        chk("t2_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t2_rsp_id", bus.rsp_id, 64'((k - 1) % 2));
      end
      if (k == 6) bus.req_valid[0] = 1'b0;
      if (k == 7) bus.req_valid[1] = 1'b0;
      tick();
    end
    #1;
    chk("t2_no_grant", bus.req_ready, 2'b00);
    chk("t2_last_hwdata", bus.Hwdata, 32'h0000_2000);
    tick(); #1;
    chk("t2_last_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t2_last_rsp_id", bus.rsp_id, 1'b1);
    tick();

    // 3: read with 5 stall cycles in the data phase
    set_req(0, 1'b0, 32'h8000_00AA, 32'h0);
    #1 chk("t3_req_ready", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0; #1;
    chk("t3_nonseq", bus.Htrans, 2'b10);
    chk("t3_hwrite", bus.Hwrite, 1'b0);
    tick();
    bus.Hreadyout = 1'b0;
    bus.Hrdata    = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_htrans", bus.Htrans, 2'b00);
      chk("t3_stall_haddr", bus.Haddr, 32'h8000_00AA);
      chk("t3_stall_rsp", bus.rsp_valid, 1'b0);
      tick();
    end
    bus.Hreadyout = 1'b1;
    #1 chk("t3_hwrite_hold", bus.Hwrite, 1'b0);
    tick(); #1;
    chk("t3_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t3_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("t3_rsp_id", bus.rsp_id, 1'b0);
    tick(); #1;
    chk("t3_rsp_pulse", bus.rsp_valid, 1'b0);

    // 4: ERROR response for 2 cycles on a write, then a clean write
    set_req(1, 1'b1, 32'h0000_0300, 32'h0000_DEAD);
    #1 chk("t4_req_ready", bus.req_ready, 2'b10);
    tick(); bus.req_valid = '0;
    tick();
    bus.Hresp     = 2'b01;
    bus.Hreadyout = 1'b0;
    #1 chk("t4_hwdata", bus.Hwdata, 32'h0000_DEAD);
    tick(); #1;
    chk("t4_no_rsp_yet", bus.rsp_valid, 1'b0);
    tick();
    bus.Hresp     = 2'b00;
    bus.Hreadyout = 1'b1;
    tick(); #1;
    chk("t4_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t4_rsp_err", bus.rsp_err, 1'b1);
    chk("t4_rsp_id", bus.rsp_id, 1'b1);
    set_req(0, 1'b1, 32'h0000_0400, 32'h0000_0044);
    #1 chk("t4b_req_ready", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0;
    tick();
    tick(); #1;
    chk("t4b_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t4b_rsp_err", bus.rsp_err, 1'b0);
    tick();

    // 5: reset in the data phase drops the transfer and resets the pointer
    set_req(0, 1'b1, 32'h0000_0500, 32'h0000_0055);
    tick(); bus.req_valid = '0;
    tick();
    bus.Hreadyout = 1'b0;
    #1 chk("t5_hwdata_inflight", bus.Hwdata, 32'h0000_0055);
    Hresetn = 1'b0;
    set_req(0, 1'b1, 32'h0000_0600, 32'h0000_0066);
    set_req(1, 1'b1, 32'h0000_0700, 32'h0000_0077);
    #1;
    chk("t5_htrans", bus.Htrans, 2'b00);
    chk("t5_hwdata", bus.Hwdata, 32'h0);
    chk("t5_haddr", bus.Haddr, 32'h0);
    chk("t5_hreadyin", bus.Hreadyin, 1'b0);
    chk("t5_req_ready", bus.req_ready, 2'b00);
    tick(); #1;
    chk("t5_no_rsp", bus.rsp_valid, 1'b0);
    Hresetn       = 1'b1;
    bus.Hreadyout = 1'b1;
    tick(); #1;
    chk("t5_first_grant", bus.req_ready, 2'b01);
    chk("t5_no_rsp_after", bus.rsp_valid, 1'b0);

    // 6: requester 1 withdraws while requester 0 is busy
    tick(); #1;
    chk("t6_busy_no_grant", bus.req_ready, 2'b00);
    chk("t6_haddr", bus.Haddr, 32'h0000_0600);
    bus.req_valid[1] = 1'b0;
    tick(); #1;
    chk("t6_regrant_0", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0; #1;
    chk("t6_nonseq", bus.Htrans, 2'b10);
    chk("t6_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t6_rsp_id", bus.rsp_id, 1'b0);
    tick();
    tick(); #1;
    chk("t6_rsp2_valid", bus.rsp_valid, 1'b1);
    chk("t6_rsp2_id", bus.rsp_id, 1'b0);
    chk("t6_no_grant", bus.req_ready, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
